// File: rtl/regfile_pkg.sv
// Shared constants and clear-engine state encoding for the register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: sweeps every entry to zero, one per cycle, then pulses clr_done.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    clr_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        clr_busy = 1'b1;
        clr_we   = 1'b1;
        // Counter wraps back to 0 on the last entry.
        cnt_d    = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ADDR) state_d = ST_DONE;
      end
      ST_DONE: begin
        clr_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_param.sv
// 1W/2R parametrised register file with run-time clear sweep and optional registered reads.
// Build option: define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int READ_REG = 0
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_zero_blk;
  logic              wr_accept;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_word [2];
  logic [DATA_W-1:0] rd_data [2];

  regfile_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
    .clk      (clk),
    .arst_n   (arst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_ready = !clr_busy;

`ifdef REGFILE_ZERO_REG_EN
  assign wr_zero_blk = (wr_addr == '0);
`else
  assign wr_zero_blk = 1'b0;
`endif

  // Blocking address 0 here also removes it from the write-first bypass below.
  assign wr_accept = wr_en && wr_ready && !wr_zero_blk;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_accept) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic zero_hit;
`ifdef REGFILE_ZERO_REG_EN
      assign zero_hit = (rd_addr[gi] == '0);
`else
      assign zero_hit = 1'b0;
`endif
      assign rd_word[gi] = zero_hit ? '0 : mem_q[rd_addr[gi]];

      if (READ_REG != 0) begin : g_reg
        logic [DATA_W-1:0] rd_q;
        always_ff @(posedge clk or negedge arst_n) begin
          if (!arst_n) begin
            rd_q <= '0;
          end else if (rd_en) begin
            rd_q <= (wr_accept && (wr_addr == rd_addr[gi])) ? wr_data : rd_word[gi];
          end
        end
        assign rd_data[gi] = rd_q;
      end else begin : g_comb
        assign rd_data[gi] = rd_word[gi];
      end
    end

    if (READ_REG == 0) begin : g_no_strobe
      logic unused_rd_en;
      assign unused_rd_en = rd_en;
    end
  endgenerate

  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];

endmodule
